riscv_mc_controller: RTL
========================

RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 Parameters SHALL be: CNT_W, default 32, retire-counter width; TIMEOUT_W, default 8, memory-wait counter width; SUPPORT_BNE, default 1, enables the bne instruction.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock
- reset  in  1  asynchronous active-high reset
- op_i  in  7  instr[6:0]
- funct3_i  in  3  instr[14:12]
- funct7b5_i  in  1  instr[30]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes the current request
REQ-003 Output ports SHALL be:
- pc_write_o  out  1
- adr_src_o  out  1  0=PC, 1=ALUOut
- ir_write_o  out  1
- mem_req_o  out  1
- mem_write_o  out  1
- reg_write_o  out  1
- result_src_o  out  2  00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a_o  out  2  00=PC, 01=oldPC, 10=rs1
- alu_src_b_o  out  2  00=rs2, 01=imm, 10=const 4
- alu_ctrl_o  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src_o  out  3  000 I, 001 S, 010 B, 011 J
- state_o  out  4
- trap_o  out  1
- trap_cause_o  out  2  01=illegal, 10=timeout
- retire_o  out  1
- instret_o  out  CNT_W

Function
REQ-004 The FSM SHALL have these states with the given encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11; state_o SHALL equal the current state.
REQ-005 All outputs not listed for a state SHALL be 0, and imm_src_o SHALL always be decoded from op_i.
REQ-006 In FETCH, the block SHALL assert mem_req_o with adr_src=0 and hold it until mem_ready_i.
REQ-007 In the ready cycle of FETCH, the block SHALL assert ir_write and pc_write with srcA=00, srcB=10, add and result_src=10, then go to DECODE.
REQ-008 In DECODE, the block SHALL drive srcA=01, srcB=01, add, and SHALL take the next state from op_i as follows:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- anything else -> TRAP (cause 01)
REQ-009 DECODE SHALL also trap with cause 01 for:
- lw or sw with funct3!=010
- R or I type with funct3 not in {000, 010, 110, 111}
- a branch with funct3!=000, except funct3=001 when SUPPORT_BNE=1
REQ-010 In MEMADR, the block SHALL drive srcA=10, srcB=01, add, then go to MEMREAD for a load or MEMWRITE for a store.
REQ-011 In MEMREAD, the block SHALL assert mem_req with adr_src=1 until ready, then go to MEMWB.
REQ-012 In MEMWB, the block SHALL drive result_src=01 and reg_write, then go to FETCH.
REQ-013 In MEMWRITE, the block SHALL assert mem_req and mem_write with adr_src=1 until ready, then go to FETCH.
REQ-014 In EXECR (srcB=00) and EXECI (srcB=01), the block SHALL drive srcA=10 and decode alu_ctrl from funct3 as follows, then go to ALUWB:
- 000 -> sub if EXECR and funct7b5=1, else add
- 010 -> slt
- 110 -> or
- 111 -> and
REQ-015 In ALUWB, the block SHALL drive result_src=00 and reg_write, then go to FETCH.
REQ-016 In BRANCH, the block SHALL drive srcA=10, srcB=00, sub, result_src=00, and SHALL assert pc_write only when taken (beq: zero_i=1; bne: zero_i=0), then go to FETCH.
REQ-017 In JAL, the block SHALL drive srcA=01, srcB=10, add, result_src=00 and pc_write, then go to ALUWB.
REQ-018 The wait counter SHALL clear on entry to FETCH, MEMREAD and MEMWRITE, and SHALL increment on each wait cycle with mem_ready_i=0.
REQ-019 When the wait counter is at 2^TIMEOUT_W-1 and mem_ready_i=0, the FSM SHALL go to TRAP with cause 10.
REQ-020 A ready arriving in that same cycle SHALL win over the timeout.
REQ-021 TRAP SHALL be absorbing: trap_o=1, trap_cause_o held, all enables 0, exit only by reset.
REQ-022 retire_o SHALL pulse for one cycle on MEMWB, MEMWRITE-with-ready, ALUWB and BRANCH.
REQ-023 instret_o SHALL increment on each retire_o pulse and SHALL wrap modulo 2^CNT_W.
REQ-024 Once asserted, mem_req_o SHALL NOT drop, nor mem_write_o or adr_src_o change, before mem_ready_i.

Reset
REQ-025 reset=1 SHALL asynchronously force state=FETCH, wait counter 0, instret_o 0, trap_o 0 and trap_cause_o 00.
REQ-026 During reset all outputs SHALL be at their FETCH values with mem_req_o=0.
REQ-027 The first mem_req_o SHALL be asserted in the first clk edge cycle after reset deasserts.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no retire.

Verification
REQ-029 add x3,x1,x2 (op 0110011, f3 000, f7b5 0), ready every cycle -> states 0,1,6,8,0; alu_ctrl 000 in EXECR; one retire; instret 1.
REQ-030 lw with 3 wait cycles on FETCH and MEMREAD -> mem_req held 4 cycles each; MEMWB result_src=01, reg_write=1; instret +1.
REQ-031 beq with zero_i=1, then bne with zero_i=0 (SUPPORT_BNE=1) -> pc_write=1 in BRANCH both times; with SUPPORT_BNE=0, bne -> TRAP cause 01.
REQ-032 op 1111111 -> TRAP, trap_o=1, cause 01, no further mem_req; reset -> FETCH, instret 0.
REQ-033 TIMEOUT_W=2, mem_ready_i held 0 in FETCH -> TRAP cause 10 after 4 wait cycles; ready on the 4th cycle -> no trap.
REQ-034 CNT_W=4, 16 retired addi -> instret_o wraps to 0.

Source files
------------

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RV32 subset control FSM with memory-wait timeout,
// illegal-instruction trap and retired-instruction counter.
module riscv_mc_controller #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_W   = 8,
    parameter int SUPPORT_BNE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7b5_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_ctrl_o,
    output logic [2:0]       imm_src_o,
    output logic [3:0]       state_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t               r_state;
    state_t               w_next;
    state_t               w_dec;
    logic [TIMEOUT_W-1:0] r_wait;
    logic [1:0]           r_cause;
    logic [1:0]           w_cause;
    logic [CNT_W-1:0]     r_instret;
    logic                 w_timeout;
    logic                 w_alu_ok;
    logic                 w_br_ok;
    logic [2:0]           w_alu;

    assign w_timeout = (r_wait == '1) && !mem_ready_i;
    assign w_alu_ok  = (funct3_i == 3'b000) || (funct3_i == 3'b010) ||
                       (funct3_i == 3'b110) || (funct3_i == 3'b111);
    assign w_br_ok   = (funct3_i == 3'b000) || ((funct3_i == 3'b001) && (SUPPORT_BNE != 0));
    assign w_alu     = (funct3_i == 3'b010) ? 3'b101 :
                       (funct3_i == 3'b110) ? 3'b011 :
                       (funct3_i == 3'b111) ? 3'b010 :
                       (r_state == EXECR && funct7b5_i) ? 3'b001 : 3'b000;
    assign w_dec     = (op_i == OP_LOAD || op_i == OP_STORE) ? ((funct3_i == 3'b010) ? MEMADR : TRAP) :
                       (op_i == OP_R)   ? (w_alu_ok ? EXECR : TRAP) :
                       (op_i == OP_I)   ? (w_alu_ok ? EXECI : TRAP) :
                       (op_i == OP_BR)  ? (w_br_ok ? BRANCH : TRAP) :
                       (op_i == OP_JAL) ? JAL : TRAP;

    assign imm_src_o    = (op_i == OP_STORE) ? 3'b001 :
                          (op_i == OP_BR)    ? 3'b010 :
                          (op_i == OP_JAL)   ? 3'b011 : 3'b000;
    assign state_o      = r_state;
    assign trap_cause_o = r_cause;
    assign instret_o    = r_instret;

    always_comb begin
        pc_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_ctrl_o   = 3'b000;
        retire_o     = 1'b0;
        trap_o       = 1'b0;
        w_next       = r_state;
        w_cause      = 2'b00;
        case (r_state)
            FETCH: begin
                // No request is presented while reset is held
                mem_req_o = !reset;
                if (!reset && mem_ready_i) begin
                    ir_write_o   = 1'b1;
                    pc_write_o   = 1'b1;
                    alu_src_b_o  = 2'b10;
                    result_src_o = 2'b10;
                    w_next       = DECODE;
                end else if (!reset && w_timeout) begin
                    w_next  = TRAP;
                    w_cause = 2'b10;
                end
            end
            DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                w_next      = w_dec;
                w_cause     = (w_dec == TRAP) ? 2'b01 : 2'b00;
            end
            MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                w_next      = (op_i == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) begin
                    w_next = MEMWB;
                end else if (w_timeout) begin
                    w_next  = TRAP;
                    w_cause = 2'b10;
                end
            end
            MEMWB: begin
                result_src_o = 2'b01;
                reg_write_o  = 1'b1;
                retire_o     = 1'b1;
                w_next       = FETCH;
            end
            MEMWRITE: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                adr_src_o   = 1'b1;
                if (mem_ready_i) begin
                    retire_o = 1'b1;
                    w_next   = FETCH;
                end else if (w_timeout) begin
                    w_next  = TRAP;
                    w_cause = 2'b10;
                end
            end
            EXECR, EXECI: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = (r_state == EXECI) ? 2'b01 : 2'b00;
                alu_ctrl_o  = w_alu;
                w_next      = ALUWB;
            end
            ALUWB: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
                w_next      = FETCH;
            end
            BRANCH: begin
                // beq takes on zero, bne on non-zero; funct3[0] selects which
                alu_src_a_o = 2'b10;
                alu_ctrl_o  = 3'b001;
                pc_write_o  = zero_i ^ funct3_i[0];
                retire_o    = 1'b1;
                w_next      = FETCH;
            end
            JAL: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write_o  = 1'b1;
                w_next      = ALUWB;
            end
            TRAP: begin
                trap_o = 1'b1;
            end
            default: begin
                w_next  = TRAP;
                w_cause = 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH;
            r_wait    <= '0;
            r_cause   <= 2'b00;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_next != r_state) ? '0 : (mem_req_o && !mem_ready_i) ? r_wait + 1'b1 : r_wait;
            if (w_next == TRAP && r_state != TRAP)
                r_cause <= w_cause;
            if (retire_o)
                r_instret <= r_instret + 1'b1;
        end
    end
endmodule
